// File: rtl/pipelined_node_link.sv
// Registered router-to-router link: flits forward, on/off and allocatable back,
// STAGES slices each way, with per-VC in-flight counters and a sticky on/off error.
package pipelined_node_link_pkg;

   localparam int VC_NUM  = 4;
   localparam int VC_ID_W = 3;

   typedef struct packed {
      logic [1:0]         kind;
      logic [VC_ID_W-1:0] vc_id;
      logic [31:0]        payload;
   } flit_t;

endpackage

module pipelined_node_link
   import pipelined_node_link_pkg::*;
#(
   parameter int  STAGES   = 2,
   parameter int  VC_COUNT = VC_NUM,
   localparam int CNT_W    = $clog2(STAGES + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  flit_t                     data_i,
   input  logic                      is_valid_i,
   output logic [VC_COUNT-1:0]       is_on_off_o,
   output logic [VC_COUNT-1:0]       is_allocatable_o,
   output flit_t                     data_o,
   output logic                      is_valid_o,
   input  logic [VC_COUNT-1:0]       is_on_off_i,
   input  logic [VC_COUNT-1:0]       is_allocatable_i,
   output logic [VC_COUNT*CNT_W-1:0] inflight_o,
   output logic [VC_COUNT-1:0]       proto_err_o
);

   if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("pipelined_node_link: STAGES must be 1..8");
   end
   if (VC_COUNT < 1 || VC_COUNT > (1 << VC_ID_W)) begin : g_bad_vc
      $error("pipelined_node_link: VC_COUNT out of range for vc_id");
   end

   localparam logic [VC_ID_W:0] VC_LIM = (VC_ID_W + 1)'(VC_COUNT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STAGES);

   logic [STAGES-1:0]   vld;
   flit_t               dat   [STAGES];
   logic [VC_COUNT-1:0] on_p  [STAGES];
   logic [VC_COUNT-1:0] al_p  [STAGES];
   logic [CNT_W-1:0]    cnt   [VC_COUNT];
   logic [VC_COUNT-1:0] enter;
   logic [VC_COUNT-1:0] leave;
   logic [VC_COUNT-1:0] err;

   // Forward slices: valid always shifts, data only moves behind a valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < STAGES; i++) begin
            dat[i] <= '0;
         end
      end else begin
         vld[0] <= is_valid_i;
         if (is_valid_i) begin
            dat[0] <= data_i;
         end
         for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) begin
               dat[i] <= dat[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            on_p[i] <= '0;
            al_p[i] <= '0;
         end
      end else begin
         on_p[0] <= is_on_off_i;
         al_p[0] <= is_allocatable_i;
         for (int i = 1; i < STAGES; i++) begin
            on_p[i] <= on_p[i-1];
            al_p[i] <= al_p[i-1];
         end
      end
   end

   assign is_valid_o       = vld[STAGES-1];
   assign data_o           = dat[STAGES-1];
   assign is_on_off_o      = on_p[STAGES-1];
   assign is_allocatable_o = al_p[STAGES-1];
   assign proto_err_o      = err;

   always_comb begin
      enter = '0;
      leave = '0;
      for (int v = 0; v < VC_COUNT; v++) begin
         enter[v] = is_valid_i && (data_i.vc_id == VC_ID_W'(v));
         leave[v] = is_valid_o && (data_o.vc_id == VC_ID_W'(v));
      end
   end

   // Counters saturate defensively; hitting a bound means the pipe is broken.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VC_COUNT; v++) begin
            cnt[v] <= '0;
         end
      end else begin
         for (int v = 0; v < VC_COUNT; v++) begin
            if (enter[v] && !leave[v]) begin
               assert (cnt[v] != CNT_MAX)
                  else $error("inflight counter overflow on vc %0d", v);
               if (cnt[v] != CNT_MAX) begin
                  cnt[v] <= cnt[v] + 1'b1;
               end
            end else if (leave[v] && !enter[v]) begin
               assert (cnt[v] != '0)
                  else $error("inflight counter underflow on vc %0d", v);
               if (cnt[v] != '0) begin
                  cnt[v] <= cnt[v] - 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= '0;
      end else begin
         assert (!is_valid_i || ({1'b0, data_i.vc_id} < VC_LIM))
            else $error("flit vc_id %0d out of range", data_i.vc_id);
         for (int v = 0; v < VC_COUNT; v++) begin
            if (enter[v] && !is_on_off_o[v]) begin
               err[v] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      inflight_o = '0;
      for (int v = 0; v < VC_COUNT; v++) begin
         inflight_o[v*CNT_W +: CNT_W] = cnt[v];
      end
   end

endmodule
